// File: rtl/oclib_pulse_arbiter_if.sv
// Request/indicator bundle for oclib_pulse_arbiter.
// The coalesced counts exist only when OCLIB_PULSE_ARBITER_COALESCE_EN is defined.
interface oclib_pulse_arbiter_if #(
   parameter int Requesters = 4,
   parameter int CountWidth = 8
);
   localparam int OwnerWidth = (Requesters > 1) ? $clog2(Requesters) : 1;

   logic [Requesters-1:0] req;
   logic [Requesters-1:0] pending;
   logic [Requesters-1:0] grant;
   logic [OwnerWidth-1:0] owner;
   logic                  out;
   logic                  busy;
`ifdef OCLIB_PULSE_ARBITER_COALESCE_EN
   logic [Requesters*CountWidth-1:0] coalesced;

   modport master (output req, input pending, grant, owner, out, busy, coalesced);
   modport slave  (input req, output pending, grant, owner, out, busy, coalesced);
`else
   modport master (output req, input pending, grant, owner, out, busy);
   modport slave  (input req, output pending, grant, owner, out, busy);
`endif
endinterface

// File: rtl/oclib_pulse_arbiter.sv
// Round-robin arbiter sharing one stretched pulse output between several event sources.
// Optional per-source coalesce counters are built when OCLIB_PULSE_ARBITER_COALESCE_EN is defined.
module oclib_pulse_arbiter #(
   parameter int Requesters  = 4,
   parameter int PulseCycles = 1000,
   parameter int GapCycles   = 100,
   parameter int CountWidth  = 8
) (
   input logic                  clock,
   input logic                  reset,
   oclib_pulse_arbiter_if.slave bus
);
   localparam int OW       = (Requesters > 1) ? $clog2(Requesters) : 1;
   localparam int MAX_CNT  = (PulseCycles > GapCycles) ? PulseCycles : GapCycles;
   localparam int CNT_W    = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PulseCycles - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = (GapCycles > 0) ? CNT_W'(GapCycles - 1) : '0;
   localparam logic [OW-1:0]    LAST_IDX   = OW'(Requesters - 1);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t                state_p0, state_nxt;
   logic [CNT_W-1:0]      cnt_p0, cnt_nxt;
   logic [Requesters-1:0] pending_p0, pending_nxt;
   logic [Requesters-1:0] grant_p0, grant_nxt;
   logic [Requesters-1:0] clr;
   logic [OW-1:0]         owner_p0, owner_nxt;
   logic [OW-1:0]         rr_p0, rr_nxt;
   logic [OW-1:0]         pick;
   logic                  out_p0, out_nxt;
   logic                  busy_p0, busy_nxt;
   logic [Requesters-1:0] req;

   assign req = bus.req;

   // First pending index at or after ptr, wrapping modulo Requesters.
   function automatic logic [OW-1:0] pick_next(input logic [Requesters-1:0] pend,
                                              input logic [OW-1:0]         ptr);
      logic [OW-1:0] sel;
      logic [OW-1:0] cand;
      logic          found;
      int            idx;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < Requesters; i++) begin
         idx = int'(ptr) + i;
         if (idx >= Requesters) idx = idx - Requesters;
         cand = OW'(idx);
         if (!found && pend[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      return sel;
   endfunction

   assign pick = pick_next(pending_p0, rr_p0);

   always_comb begin
      state_nxt = state_p0;
      cnt_nxt   = cnt_p0;
      grant_nxt = grant_p0;
      owner_nxt = owner_p0;
      rr_nxt    = rr_p0;
      out_nxt   = out_p0;
      busy_nxt  = busy_p0;
      clr       = '0;
      case (state_p0)
         IDLE: begin
            if (|pending_p0) begin
               state_nxt       = PULSE;
               grant_nxt       = '0;
               grant_nxt[pick] = 1'b1;
               owner_nxt       = pick;
               out_nxt         = 1'b1;
               busy_nxt        = 1'b1;
               clr[pick]       = 1'b1;
               cnt_nxt         = PULSE_LOAD;
            end
         end
         PULSE: begin
            if (cnt_p0 == '0) begin
               grant_nxt = '0;
               out_nxt   = 1'b0;
               rr_nxt    = (owner_p0 == LAST_IDX) ? '0 : owner_p0 + OW'(1);
               if (GapCycles > 0) begin
                  state_nxt = GAP;
                  cnt_nxt   = GAP_LOAD;
               end else begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end
            end else begin
               cnt_nxt = cnt_p0 - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_p0 == '0) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt_p0 - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A fresh request on the bit being granted re-arms it.
      pending_nxt = (pending_p0 & ~clr) | req;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_p0   <= IDLE;
         cnt_p0     <= '0;
         pending_p0 <= '0;
         grant_p0   <= '0;
         owner_p0   <= '0;
         rr_p0      <= '0;
         out_p0     <= 1'b0;
         busy_p0    <= 1'b0;
      end else begin
         state_p0   <= state_nxt;
         cnt_p0     <= cnt_nxt;
         pending_p0 <= pending_nxt;
         grant_p0   <= grant_nxt;
         owner_p0   <= owner_nxt;
         rr_p0      <= rr_nxt;
         out_p0     <= out_nxt;
         busy_p0    <= busy_nxt;
      end
   end

   assign bus.pending = pending_p0;
   assign bus.grant   = grant_p0;
   assign bus.owner   = owner_p0;
   assign bus.out     = out_p0;
   assign bus.busy    = busy_p0;

`ifdef OCLIB_PULSE_ARBITER_COALESCE_EN
   logic [Requesters*CountWidth-1:0] coal_p0;

   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
      return (&v) ? v : v + CountWidth'(1);
   endfunction

   // A request landing on an already-pending bit is absorbed; count it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         coal_p0 <= '0;
      end else begin
         for (int i = 0; i < Requesters; i++) begin
            if (req[i] && pending_p0[i])
               coal_p0[i*CountWidth +: CountWidth] <= sat_inc(coal_p0[i*CountWidth +: CountWidth]);
         end
      end
   end

   assign bus.coalesced = coal_p0;
`endif
endmodule

// File: tb/tb_oclib_pulse_arbiter.sv
// Self-checking bench for oclib_pulse_arbiter: directed scenarios plus randomized traffic vs a timeline model.
module tb_oclib_pulse_arbiter;
   localparam int R = 4;
   localparam int P = 5;
   localparam int G = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   oclib_pulse_arbiter_if #(.Requesters(R), .CountWidth(8)) a_if ();
   oclib_pulse_arbiter_if #(.Requesters(R), .CountWidth(8)) b_if ();

   oclib_pulse_arbiter #(.Requesters(R), .PulseCycles(P), .GapCycles(G), .CountWidth(8)) dut_a (
      .clock(clk), .reset(rst_n), .bus(a_if));
   oclib_pulse_arbiter #(.Requesters(R), .PulseCycles(1), .GapCycles(0), .CountWidth(8)) dut_b (
      .clock(clk), .reset(rst_n), .bus(b_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timeline model: a grant at edge g owns the pin for P edges, then G gap edges, then one idle edge.
   int       m_edge, m_tg, m_next_ok, m_rr, m_owner;
   bit       m_act;
   bit [3:0] m_pend;
   int       m_coal [4];

   task automatic model_reset();
      m_edge = 0; m_tg = 0; m_next_ok = 0; m_rr = 0; m_owner = 0; m_act = 0; m_pend = '0;
      for (int i = 0; i < 4; i++) m_coal[i] = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      bit [3:0] pb;
      bit       found;
      int       k;
      pb = m_pend;
      m_edge++;
      if (m_edge >= m_next_ok && m_pend != 0) begin
         found = 0;
         for (int j = 0; j < R; j++) begin
            k = (m_rr + j) % R;
            if (!found && m_pend[k]) begin found = 1; m_owner = k; end
         end
         m_pend[m_owner] = 1'b0;
         m_tg = m_edge; m_act = 1; m_next_ok = m_edge + P + G + 1;
         m_rr = (m_owner + 1) % R;
      end
      for (int i = 0; i < 4; i++) if (r[i] && pb[i] && m_coal[i] < 255) m_coal[i]++;
      m_pend = m_pend | r;
   endtask

   task automatic tick(input logic [3:0] ra, input logic [3:0] rb);
      a_if.req = ra;
      b_if.req = rb;
      @(posedge clk);
      model_step(ra);
      @(negedge clk);
   endtask

   task automatic do_reset();
      a_if.req = '0; b_if.req = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_if.req = '0; b_if.req = '0;
      @(negedge clk);
      checks++;
      if ({a_if.pending, a_if.grant, a_if.owner, a_if.out, a_if.busy} !== '0) begin
         errors++;
         $display("FAIL reset_state got pend=%b grant=%b owner=%0d out=%b busy=%b exp all 0",
                  a_if.pending, a_if.grant, a_if.owner, a_if.out, a_if.busy);
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 3; i++) begin
         tick(4'b0, 4'b0);
         checks++;
         if (a_if.out !== 1'b0 || a_if.busy !== 1'b0 || b_if.out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle tick %0d got out=%b busy=%b bout=%b exp 0", i, a_if.out, a_if.busy, b_if.out);
         end
      end
   endtask

   task automatic test_single();
      logic eo, eb;
      do_reset();
      tick(4'b0100, 4'b0);
      checks++;
      if (a_if.pending !== 4'b0100 || a_if.out !== 1'b0) begin
         errors++;
         $display("FAIL single_pending got %b out=%b exp 0100 out=0", a_if.pending, a_if.out);
      end
      for (int i = 2; i <= 10; i++) begin
         tick(4'b0, 4'b0);
         eo = (i >= 2 && i <= 6);
         eb = (i >= 2 && i <= 8);
         checks++;
         if (a_if.out !== eo || a_if.busy !== eb || a_if.grant !== (eo ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL single_pulse tick %0d got out=%b busy=%b grant=%b exp out=%b busy=%b",
                     i, a_if.out, a_if.busy, a_if.grant, eo, eb);
         end
      end
      checks++;
      if (a_if.owner !== 2'd2) begin
         errors++;
         $display("FAIL single_owner got %0d exp 2", a_if.owner);
      end
   endtask

   task automatic test_all_four();
      logic       eo;
      logic [3:0] eg;
      do_reset();
      tick(4'b1111, 4'b0);
      checks++;
      if (a_if.pending !== 4'b1111) begin
         errors++;
         $display("FAIL all4_pending got %b exp 1111", a_if.pending);
      end
      for (int i = 2; i <= 36; i++) begin
         tick(4'b0, 4'b0);
         eo = 1'b0; eg = 4'b0;
         for (int j = 0; j < 4; j++)
            if (i >= 2 + 8*j && i <= 6 + 8*j) begin eo = 1'b1; eg = 4'(1 << j); end
         checks++;
         if (a_if.out !== eo || a_if.grant !== eg) begin
            errors++;
            $display("FAIL all4_seq tick %0d got out=%b grant=%b exp out=%b grant=%b", i, a_if.out, a_if.grant, eo, eg);
         end
      end
   endtask

   task automatic test_coalesce();
      int   rises;
      logic prev;
      do_reset();
      rises = 0; prev = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         tick((i == 1 || i == 3 || i == 4 || i == 5) ? 4'b0010 : 4'b0000, 4'b0);
         if (a_if.out && !prev) rises++;
         prev = a_if.out;
         if (i == 10) begin
            checks++;
            if (a_if.grant !== 4'b0010) begin
               errors++;
               $display("FAIL coalesce_regrant got %b exp 0010", a_if.grant);
            end
         end
      end
      checks++;
      if (rises !== 2) begin
         errors++;
         $display("FAIL coalesce_pulses got %0d exp 2", rises);
      end
      checks++;
      if (a_if.pending !== 4'b0) begin
         errors++;
         $display("FAIL coalesce_drain got %b exp 0000", a_if.pending);
      end
`ifdef OCLIB_PULSE_ARBITER_COALESCE_EN
      checks++;
      if (a_if.coalesced[8 +: 8] !== 8'd2) begin
         errors++;
         $display("FAIL coalesce_count got %0d exp 2", a_if.coalesced[8 +: 8]);
      end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      tick(4'b0001, 4'b0);
      tick(4'b0001, 4'b0);
      checks++;
      if (a_if.grant !== 4'b0001 || a_if.pending !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_setwins got grant=%b pend=%b exp 0001/0001", a_if.grant, a_if.pending);
      end
      for (int i = 3; i <= 10; i++) begin
         tick(4'b0, 4'b0);
         if (i == 9) begin
            checks++;
            if (a_if.out !== 1'b0 || a_if.busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle got out=%b busy=%b exp 0/0", a_if.out, a_if.busy);
            end
         end
      end
      checks++;
      if (a_if.grant !== 4'b0001 || a_if.out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_regrant got grant=%b out=%b exp 0001/1", a_if.grant, a_if.out);
      end
   endtask

   task automatic test_fairness();
      int         owners [4];
      int         j;
      logic [3:0] eg;
      owners = '{0, 3, 0, 0};
      do_reset();
      tick(4'b1001, 4'b0);
      for (int i = 2; i <= 33; i++) begin
         tick(4'b0001, 4'b0);
         j  = (i - 2) / 8;
         eg = ((i - 2) % 8 < 5) ? 4'(1 << owners[j]) : 4'b0;
         checks++;
         if (a_if.grant !== eg) begin
            errors++;
            $display("FAIL fair_grant tick %0d got %b exp %b", i, a_if.grant, eg);
         end
      end
   endtask

   task automatic test_nogap();
      logic       eo[6];
      logic [3:0] eg[6];
      eo = '{0, 0, 1, 0, 1, 0};
      eg = '{4'b0, 4'b0, 4'b0001, 4'b0, 4'b0010, 4'b0};
      do_reset();
      tick(4'b0, 4'b0011);
      checks++;
      if (b_if.pending !== 4'b0011) begin
         errors++;
         $display("FAIL nogap_pending got %b exp 0011", b_if.pending);
      end
      for (int i = 2; i <= 5; i++) begin
         tick(4'b0, 4'b0);
         checks++;
         if (b_if.out !== eo[i] || b_if.busy !== eo[i] || b_if.grant !== eg[i]) begin
            errors++;
            $display("FAIL nogap_seq tick %0d got out=%b busy=%b grant=%b exp out=%b grant=%b",
                     i, b_if.out, b_if.busy, b_if.grant, eo[i], eg[i]);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      do_reset();
      tick(4'b0100, 4'b0);
      tick(4'b0, 4'b0);
      tick(4'b0001, 4'b0);
      tick(4'b0, 4'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (a_if.out !== 1'b0 || a_if.grant !== 4'b0 || a_if.pending !== 4'b0 || a_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async got out=%b grant=%b pend=%b busy=%b exp 0",
                  a_if.out, a_if.grant, a_if.pending, a_if.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 1; i <= 12; i++) begin
         tick(4'b0, 4'b0);
         checks++;
         if (a_if.out !== 1'b0 || a_if.pending !== 4'b0) begin
            errors++;
            $display("FAIL midreset_quiet tick %0d got out=%b pend=%b exp 0", i, a_if.out, a_if.pending);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       eo, eb;
      logic [3:0] eg;
      int         d;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 11) == 0);
         tick(r, 4'b0);
         d  = m_edge - m_tg;
         eo = m_act && d < P;
         eb = m_act && d < P + G;
         eg = eo ? 4'(1 << m_owner) : 4'b0;
         checks++;
         if (a_if.out !== eo || a_if.busy !== eb || a_if.grant !== eg) begin
            errors++;
            $display("FAIL rand_out cyc %0d got out=%b busy=%b grant=%b exp out=%b busy=%b grant=%b",
                     n, a_if.out, a_if.busy, a_if.grant, eo, eb, eg);
         end
         checks++;
         if (a_if.pending !== m_pend || a_if.owner !== 2'(m_owner)) begin
            errors++;
            $display("FAIL rand_state cyc %0d got pend=%b owner=%0d exp pend=%b owner=%0d",
                     n, a_if.pending, a_if.owner, m_pend, m_owner);
         end
`ifdef OCLIB_PULSE_ARBITER_COALESCE_EN
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_if.coalesced[i*8 +: 8] !== 8'(m_coal[i])) begin
               errors++;
               $display("FAIL rand_coal cyc %0d src %0d got %0d exp %0d", n, i, a_if.coalesced[i*8 +: 8], m_coal[i]);
            end
         end
`endif
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      a_if.req = '0;
      b_if.req = '0;
      model_reset();
      test_reset();
      test_single();
      test_all_four();
      test_coalesce();
      test_back_to_back();
      test_fairness();
      test_nogap();
      test_reset_mid_pulse();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
